// File: rtl/uart_ram_loader.sv
// UART boot loader: receives 8N1 bytes, pairs them low-byte-first into 16-bit
// words and writes them sequentially into the upper half of the block RAM.
module uart_ram_loader #(
  parameter int          DIVISOR   = 278,
  parameter logic [10:0] BASE_ADDR = 11'h400,
  parameter int          WORDS     = 1024
) (
  input  logic        clk,
  input  logic        reset_b,
  input  logic        rxd,
  input  logic        start,
  output logic [10:0] mem_address,
  output logic [15:0] mem_data,
  output logic        mem_data_oe,
  output logic        mem_rnw,
  output logic        mem_cs_b,
  output logic        busy,
  output logic        done,
  output logic        frame_err
);

  localparam int CW = $clog2(DIVISOR);
  localparam int NW = $clog2(WORDS + 1);
  localparam logic [CW-1:0] HALF = CW'(DIVISOR / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(DIVISOR - 1);
  localparam logic [NW-1:0] LAST = NW'(WORDS);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} ld_state_e;

  logic            rxd_meta_q, rxd_sync_q, rxd_prev_q;
  rx_state_e       rx_q, rx_d;
  ld_state_e       ld_q, ld_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic [10:0]     addr_q, addr_d;
  logic [15:0]     data_q, data_d;
  logic [NW-1:0]   count_q, count_d;
  logic            phase_q, phase_d;
  logic            ferr_q, ferr_d;
  logic            byte_vld;

  always_comb begin
    rx_d     = rx_q;
    ld_d     = ld_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    addr_d   = addr_q;
    data_d   = data_q;
    count_d  = count_q;
    phase_d  = phase_q;
    ferr_d   = ferr_q;
    byte_vld = 1'b0;

    // Receiver only runs while a load is armed; otherwise parked in idle.
    if (ld_q == LOAD) begin
      unique case (rx_q)
        RX_IDLE: begin
          if (rxd_prev_q && !rxd_sync_q) begin
            rx_d  = RX_START;
            cnt_d = HALF;
          end
        end
        RX_START: begin
          if (cnt_q == '0) begin
            if (rxd_sync_q) begin
              rx_d = RX_IDLE;
            end else begin
              rx_d  = RX_DATA;
              cnt_d = FULL;
              bit_d = 3'd0;
            end
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        RX_DATA: begin
          if (cnt_q == '0) begin
            shift_d = {rxd_sync_q, shift_q[7:1]};
            cnt_d   = FULL;
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) rx_d = RX_STOP;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        RX_STOP: begin
          if (cnt_q == '0) begin
            rx_d = RX_IDLE;
            if (rxd_sync_q) byte_vld = 1'b1;
            else            ferr_d   = 1'b1;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        default: rx_d = RX_IDLE;
      endcase
    end else begin
      rx_d = RX_IDLE;
    end

    unique case (ld_q)
      IDLE, DONE: begin
        if (start) begin
          ld_d    = LOAD;
          ferr_d  = 1'b0;
          addr_d  = BASE_ADDR;
          count_d = '0;
          phase_d = 1'b0;
        end
      end
      LOAD: begin
        if (byte_vld) begin
          if (!phase_q) begin
            data_d[7:0] = shift_q;
            phase_d     = 1'b1;
          end else begin
            data_d[15:8] = shift_q;
            phase_d      = 1'b0;
            ld_d         = WRITE;
          end
        end
      end
      WRITE: begin
        addr_d  = addr_q + 11'd1;
        count_d = count_q + NW'(1);
        ld_d    = (count_q + NW'(1) == LAST) ? DONE : LOAD;
      end
      default: ld_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
      rxd_prev_q <= 1'b1;
      rx_q       <= RX_IDLE;
      ld_q       <= IDLE;
      cnt_q      <= '0;
      bit_q      <= 3'd0;
      shift_q    <= 8'h00;
      addr_q     <= BASE_ADDR;
      data_q     <= 16'h0000;
      count_q    <= '0;
      phase_q    <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      rxd_meta_q <= rxd;
      rxd_sync_q <= rxd_meta_q;
      rxd_prev_q <= rxd_sync_q;
      rx_q       <= rx_d;
      ld_q       <= ld_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      count_q    <= count_d;
      phase_q    <= phase_d;
      ferr_q     <= ferr_d;
    end
  end

  // Bus strobes decode straight from the registered state, so cs/rnw/oe
  // move together and the write cycle is exactly one clock wide.
  assign mem_address = addr_q;
  assign mem_data    = data_q;
  assign mem_cs_b    = (ld_q != WRITE);
  assign mem_rnw     = (ld_q != WRITE);
  assign mem_data_oe = (ld_q == WRITE);
  assign busy        = (ld_q == LOAD) || (ld_q == WRITE);
  assign done        = (ld_q == DONE);
  assign frame_err   = ferr_q;

endmodule

// File: tb/tb_uart_ram_loader.sv
// Directed bench for uart_ram_loader with a RAM model and a bus protocol monitor.
module tb_uart_ram_loader;
  localparam int          DIV   = 8;
  localparam int          WORDS = 4;
  localparam logic [10:0] BASE  = 11'h400;

  logic        clk, reset_b, rxd, start;
  logic [10:0] mem_address;
  logic [15:0] mem_data;
  logic        mem_data_oe, mem_rnw, mem_cs_b, busy, done, frame_err;

  uart_ram_loader #(.DIVISOR(DIV), .BASE_ADDR(BASE), .WORDS(WORDS)) dut (
    .clk(clk), .reset_b(reset_b), .rxd(rxd), .start(start),
    .mem_address(mem_address), .mem_data(mem_data), .mem_data_oe(mem_data_oe),
    .mem_rnw(mem_rnw), .mem_cs_b(mem_cs_b), .busy(busy), .done(done),
    .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int mon_err = 0, cs_run = 0, cyc = 0, wr_cyc = -1, done_cyc = -1;
  logic done_prev = 1'b0;
  logic [26:0] wr_log[$];
  logic [15:0] ram [0:2047];

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (reset_b && !mem_cs_b && !mem_rnw) begin
      ram[mem_address] = mem_data;
      wr_log.push_back({mem_address, mem_data});
      wr_cyc = cyc;
    end
  end

  always @(negedge clk) begin
    if (mem_data_oe && (mem_rnw || mem_cs_b)) mon_err++;
    if (!mem_cs_b && (mem_rnw || !mem_data_oe)) mon_err++;
    if (!mem_cs_b && mem_address < 11'h400) mon_err++;
    cs_run = mem_cs_b ? 0 : cs_run + 1;
    if (cs_run > 1) mon_err++;
    if (done && !done_prev) done_cyc = cyc;
    done_prev = done;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rxd = 1'b0; tick(DIV);
    for (int i = 0; i < 8; i++) begin rxd = b[i]; tick(DIV); end
    rxd = stop; tick(DIV);
    rxd = 1'b1; tick(2);
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(1); start = 1'b0;
  endtask

  task automatic test_reset();
    reset_b = 1'b0; rxd = 1'b1; start = 1'b0;
    tick(3);
    tests++;
    if ({mem_address, mem_data, mem_data_oe, mem_rnw, mem_cs_b, busy, done, frame_err} !==
        {BASE, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL reset_outputs: addr=%h data=%h oe=%b rnw=%b csb=%b busy=%b done=%b ferr=%b, want 400 0000 0 1 1 0 0 0",
               mem_address, mem_data, mem_data_oe, mem_rnw, mem_cs_b, busy, done, frame_err);
    end
    reset_b = 1'b1; tick(2);
    tests++;
    if ({busy, done} !== 2'b00) begin
      fails++; $display("FAIL reset_release: busy/done=%b want 00", {busy, done});
    end
  endtask

  task automatic test_ignored_before_start();
    wr_log.delete();
    send_byte(8'h55, 1'b1); tick(DIV);
    tests++;
    if (wr_log.size() != 0 || busy !== 1'b0) begin
      fails++; $display("FAIL pre_start_ignored: writes=%0d busy=%b want 0 0", wr_log.size(), busy);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b [4];
    b = '{8'h34, 8'h12, 8'h78, 8'h56};
    wr_log.delete();
    pulse_start(); tick(1);
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (busy !== 1'b1) begin fails++; $display("FAIL busy_hold[%0d]: busy=%b want 1", i, busy); end
      send_byte(b[i], 1'b1);
    end
    tick(DIV);
    tests++;
    if (wr_log.size() != 2) begin
      fails++; $display("FAIL two_writes: count=%0d want 2", wr_log.size());
    end else if (wr_log[0] !== {11'h400, 16'h1234} || wr_log[1] !== {11'h401, 16'h5678}) begin
      fails++; $display("FAIL two_writes: got %h %h want 4001234 4015678", wr_log[0], wr_log[1]);
    end
    tests++;
    if (mem_address !== 11'h402) begin
      fails++; $display("FAIL addr_after_two: got %h want 402", mem_address);
    end
    rxd = 1'b0; tick(DIV); rxd = 1'b1; tick(2 * DIV);
    #2 reset_b = 1'b0;
    #1;
    tests++;
    if ({mem_address, mem_data, mem_data_oe, mem_rnw, mem_cs_b, busy, done, frame_err} !==
        {BASE, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL async_reset_mid: addr=%h data=%h oe=%b rnw=%b csb=%b busy=%b done=%b ferr=%b",
               mem_address, mem_data, mem_data_oe, mem_rnw, mem_cs_b, busy, done, frame_err);
    end
    tick(DIV); rxd = 1'b0; tick(DIV);
    reset_b = 1'b1; rxd = 1'b1; tick(4 * DIV);
    tests++;
    if (wr_log.size() != 2 || busy !== 1'b0) begin
      fails++; $display("FAIL after_reset_quiet: writes=%0d busy=%b want 2 0", wr_log.size(), busy);
    end
  endtask

  task automatic test_full_load();
    logic [15:0] exp_w [4];
    exp_w = '{16'h0100, 16'h0302, 16'h0504, 16'h0706};
    wr_log.delete(); done_cyc = -1;
    pulse_start();
    for (int i = 0; i < 8; i++) send_byte(8'(i), 1'b1);
    tick(DIV);
    tests++;
    if (wr_log.size() != 4) begin
      fails++; $display("FAIL full_load_count: got %0d want 4", wr_log.size());
    end else begin
      for (int i = 0; i < 4; i++)
        if (wr_log[i] !== {BASE + 11'(i), exp_w[i]} || ram[BASE + 11'(i)] !== exp_w[i]) begin
          fails++; $display("FAIL full_load_word[%0d]: got %h want %h", i, wr_log[i], {BASE + 11'(i), exp_w[i]});
        end
    end
    tests++;
    if ({done, busy, mem_address} !== {1'b1, 1'b0, 11'h404}) begin
      fails++; $display("FAIL done_state: done=%b busy=%b addr=%h want 1 0 404", done, busy, mem_address);
    end
    tests++;
    if (done_cyc < 0 || done_cyc != wr_cyc) begin
      fails++; $display("FAIL done_timing: done cycle %0d, last write cycle %0d, want equal", done_cyc, wr_cyc);
    end
  endtask

  task automatic test_frame_err();
    pulse_start(); tick(1);
    tests++;
    if ({frame_err, busy, done} !== 3'b010) begin
      fails++; $display("FAIL rearm_flags: ferr/busy/done=%b want 010", {frame_err, busy, done});
    end
    wr_log.delete();
    send_byte(8'h34, 1'b0); tick(DIV);
    tests++;
    if (frame_err !== 1'b1 || mem_data !== 16'h0706 || wr_log.size() != 0) begin
      fails++; $display("FAIL framing: ferr=%b data=%h writes=%0d want 1 0706 0", frame_err, mem_data, wr_log.size());
    end
    send_byte(8'h34, 1'b1); send_byte(8'h12, 1'b1); tick(DIV);
    tests++;
    if (wr_log.size() != 1 || wr_log[0] !== {11'h400, 16'h1234} || frame_err !== 1'b1) begin
      fails++; $display("FAIL after_framing: writes=%0d ferr=%b want 1 entry 4001234, ferr 1", wr_log.size(), frame_err);
    end
  endtask

  task automatic test_glitch();
    wr_log.delete();
    rxd = 1'b0; tick(2); rxd = 1'b1; tick(2 * DIV);
    tests++;
    if (wr_log.size() != 0 || busy !== 1'b1 || mem_data !== 16'h1234 || frame_err !== 1'b1) begin
      fails++; $display("FAIL glitch: writes=%0d busy=%b data=%h ferr=%b want 0 1 1234 1",
                        wr_log.size(), busy, mem_data, frame_err);
    end
  endtask

  task automatic test_start_ignored();
    wr_log.delete();
    pulse_start(); tick(1);
    tests++;
    if (mem_address !== 11'h401 || busy !== 1'b1) begin
      fails++; $display("FAIL start_in_load: addr=%h busy=%b want 401 1", mem_address, busy);
    end
    send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1);
    pulse_start();
    send_byte(8'h33, 1'b1); send_byte(8'h44, 1'b1);
    send_byte(8'h55, 1'b1); send_byte(8'h66, 1'b1);
    tick(DIV);
    tests++;
    if (wr_log.size() != 3) begin
      fails++; $display("FAIL ignored_start_writes: count=%0d want 3", wr_log.size());
    end else if (wr_log[0] !== {11'h401, 16'h2211} || wr_log[1] !== {11'h402, 16'h4433} ||
                 wr_log[2] !== {11'h403, 16'h6655}) begin
      fails++; $display("FAIL ignored_start_writes: got %h %h %h", wr_log[0], wr_log[1], wr_log[2]);
    end
    tests++;
    if ({done, mem_address, frame_err} !== {1'b1, 11'h404, 1'b1}) begin
      fails++; $display("FAIL ignored_start_done: done=%b addr=%h ferr=%b want 1 404 1", done, mem_address, frame_err);
    end
  endtask

  task automatic test_rearm();
    wr_log.delete();
    send_byte(8'h99, 1'b1); tick(DIV);
    tests++;
    if (wr_log.size() != 0 || done !== 1'b1) begin
      fails++; $display("FAIL done_ignores_rx: writes=%0d done=%b want 0 1", wr_log.size(), done);
    end
    pulse_start(); tick(1);
    tests++;
    if ({frame_err, done, busy, mem_address} !== {1'b0, 1'b0, 1'b1, 11'h400}) begin
      fails++; $display("FAIL rearm: ferr=%b done=%b busy=%b addr=%h want 0 0 1 400", frame_err, done, busy, mem_address);
    end
    send_byte(8'hCD, 1'b1); send_byte(8'hAB, 1'b1); tick(DIV);
    tests++;
    if (wr_log.size() != 1 || wr_log[0] !== {11'h400, 16'hABCD} || ram[11'h400] !== 16'hABCD) begin
      fails++; $display("FAIL rearm_write: writes=%0d ram400=%h want 1 ABCD", wr_log.size(), ram[11'h400]);
    end
  endtask

  task automatic test_monitor();
    tests++;
    if (mon_err != 0) begin
      fails++; $display("FAIL bus_protocol: %0d violations, want 0", mon_err);
    end
  endtask

  initial begin
    test_reset();
    test_ignored_before_start();
    test_reset_mid();
    test_full_load();
    test_frame_err();
    test_glitch();
    test_start_ignored();
    test_rearm();
    test_monitor();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
